// File: rtl/hash_rx_pkg.sv
// rtl/hash_rx_pkg.sv - shared constants and state encodings for the digest receive path
package hash_rx_pkg;

  localparam logic [7:0]   SYNC_BYTE    = 8'hA5;
  localparam int           HASH_BYTES   = 16;
  localparam logic [0:127] DEFAULT_HASH = 128'haef656fe0f5a36d58ae1029630ba25e2;

  typedef enum logic [3:0] {
    RX_IDLE  = 4'd0,
    RX_START = 4'd1,
    RX_DATA  = 4'd2,
    RX_STOP  = 4'd3
  } rx_state_t;

  typedef enum logic [3:0] {
    FR_WAIT_SYNC = 4'd0,
    FR_PAYLOAD   = 4'd1,
    FR_CHECK     = 4'd2
  } frame_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: 2-FF synchronizer, start-edge detect, mid-bit sampling
module uart_rx_byte
  import hash_rx_pkg::*;
#(
  parameter int CPB = 138
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       stop_err,
  active
);

  localparam int             HALF    = CPB / 2;
  localparam int             CW      = $clog2(CPB + 1);
  localparam logic [CW-1:0]  HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0]  CPB_M1  = CW'(CPB - 1);

  rx_state_t     r_state, w_state_nxt;
  logic          r_sync1, r_sync2, r_sync_d;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_byte_valid, w_byte_valid_nxt;
  logic          r_stop_err, w_stop_err_nxt;
  logic          w_fall;

  // r_sync_d holds the previous synchronized level so a start edge is a registered compare
  assign w_fall = r_sync_d & ~r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_sync_d     <= 1'b1;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_sync1      <= rx;
      r_sync2      <= r_sync1;
      r_sync_d     <= r_sync2;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_stop_err   <= w_stop_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt + 1'b1;
    w_bit_idx_nxt    = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_byte_valid_nxt = 1'b0;
    w_stop_err_nxt   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = r_sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == CPB_M1) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {r_sync2, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == CPB_M1) begin
          w_cnt_nxt        = '0;
          w_state_nxt      = RX_IDLE;
          w_byte_valid_nxt = r_sync2;
          w_stop_err_nxt   = ~r_sync2;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  assign data       = r_shift;
  assign byte_valid = r_byte_valid;
  assign stop_err   = r_stop_err;
  assign active     = (r_state != RX_IDLE);

endmodule

// File: rtl/hash_rx.sv
// rtl/hash_rx.sv - frames sync + 16 digest bytes + XOR checksum into a validated target digest
module hash_rx
  import hash_rx_pkg::*;
#(
  parameter int fsm_clk_freq = 16000000,
  parameter int baud         = 115200,
  parameter int timeout_bits = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rx,
  output logic         rx_led,
  output logic [0:127] hash_out,
  output logic         hash_valid,
  output logic         frame_err,
  output logic         busy
);

  localparam int            CPB       = fsm_clk_freq / baud;
  localparam int            TO_CYCLES = timeout_bits * CPB;
  localparam int            TW        = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(HASH_BYTES - 1);

  logic [7:0]    w_data;
  logic          w_byte_valid, w_stop_err, w_active;

  frame_state_t  r_fstate, w_fstate_nxt;
  logic [3:0]    r_index;
  logic [7:0]    r_xor;
  logic [0:127]  r_shadow;
  logic [0:127]  r_hash;
  logic [TW-1:0] r_to_cnt;
  logic          r_hash_valid, r_frame_err;
  logic          w_accept, w_mismatch, w_timeout;

  uart_rx_byte #(.CPB(CPB)) u_byte (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (w_data),
    .byte_valid (w_byte_valid),
    .stop_err   (w_stop_err),
    .active     (w_active)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fstate <= FR_WAIT_SYNC;
    end else begin
      r_fstate <= w_fstate_nxt;
    end
  end

  // A byte arriving always wins over an expiring timeout; the counter restarts on it
  always_comb begin
    w_fstate_nxt = r_fstate;
    w_accept     = 1'b0;
    w_mismatch   = 1'b0;
    w_timeout    = 1'b0;
    if (w_stop_err) begin
      w_fstate_nxt = FR_WAIT_SYNC;
    end else if (w_byte_valid) begin
      case (r_fstate)
        FR_WAIT_SYNC: if (w_data == SYNC_BYTE) w_fstate_nxt = FR_PAYLOAD;
        FR_PAYLOAD:   if (r_index == LAST_IDX) w_fstate_nxt = FR_CHECK;
        FR_CHECK: begin
          w_fstate_nxt = FR_WAIT_SYNC;
          w_accept     = (w_data == r_xor);
          w_mismatch   = (w_data != r_xor);
        end
        default:      w_fstate_nxt = FR_WAIT_SYNC;
      endcase
    end else if (r_fstate != FR_WAIT_SYNC && r_to_cnt == TO_LAST) begin
      w_timeout    = 1'b1;
      w_fstate_nxt = FR_WAIT_SYNC;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index      <= '0;
      r_xor        <= '0;
      r_shadow     <= '0;
      r_hash       <= DEFAULT_HASH;
      r_to_cnt     <= '0;
      r_hash_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_hash_valid <= w_accept;
      r_frame_err  <= w_stop_err | w_mismatch | w_timeout;
      if (w_byte_valid) begin
        r_to_cnt <= TW'(1);
      end else if (r_fstate != FR_WAIT_SYNC) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_byte_valid && r_fstate == FR_WAIT_SYNC) begin
        r_index <= '0;
        r_xor   <= '0;
      end
      if (w_byte_valid && r_fstate == FR_PAYLOAD) begin
        r_shadow[{r_index, 3'b000} +: 8] <= w_data;
        r_xor                            <= r_xor ^ w_data;
        r_index                          <= r_index + 4'd1;
      end
      if (w_accept) r_hash <= r_shadow;
    end
  end

  assign rx_led     = w_active;
  assign hash_out   = r_hash;
  assign hash_valid = r_hash_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_fstate != FR_WAIT_SYNC);

endmodule

// File: tb/tb_hash_rx.sv
// tb/tb_hash_rx.sv - directed bench for hash_rx at CPB=10
module tb_hash_rx;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 100_000;
  localparam int TO_BITS = 20;
  localparam int CPB     = 10;
  localparam int HALF    = 5;
  localparam int TO_CYC  = TO_BITS * CPB;

  localparam logic [127:0] H_DEFAULT = 128'haef656fe0f5a36d58ae1029630ba25e2;
  localparam logic [127:0] H_COUNT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] H_SYNCDAT = 128'ha5a50102030405060708090a0b0c0d0e;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx      = 1'b1;
  logic         rx_led;
  logic [0:127] hash_out;
  logic         hash_valid;
  logic         frame_err;
  logic         busy;

  int n_checks    = 0;
  int n_fail      = 0;
  int hv_total    = 0;
  int fe_total    = 0;
  int both_total  = 0;
  int stray_total = 0;
  logic [0:127] prev_hash = '0;

  hash_rx #(
    .fsm_clk_freq (CLK_HZ),
    .baud         (BAUD),
    .timeout_bits (TO_BITS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .rx_led     (rx_led),
    .hash_out   (hash_out),
    .hash_valid (hash_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hash_valid === 1'b1) hv_total++;
    if (frame_err === 1'b1) fe_total++;
    if (hash_valid === 1'b1 && frame_err === 1'b1) both_total++;
    if (reset_n && hash_valid !== 1'b1 && hash_out !== prev_hash) stray_total++;
    prev_hash = hash_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [127:0] p, input logic [7:0] cks);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(p[127-8*i -: 8], 1'b1);
    send_byte(cks, 1'b1);
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    n_checks++; if (hash_out !== H_DEFAULT) begin n_fail++; $display("FAIL reset_hash: got %h expected %h", hash_out, H_DEFAULT); end
    n_checks++; if (hash_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hash_valid: got %b expected 0", hash_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (rx_led !== 1'b0) begin n_fail++; $display("FAIL reset_rx_led: got %b expected 0", rx_led); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_good_frame;
    int hv0, fe0;
    hv0 = hv_total; fe0 = fe_total;
    send_frame(H_COUNT, 8'h00);
    n_checks++; if (hv_total - hv0 !== 1) begin n_fail++; $display("FAIL good_hv_count: got %0d expected 1", hv_total - hv0); end
    n_checks++; if (fe_total - fe0 !== 0) begin n_fail++; $display("FAIL good_fe_count: got %0d expected 0", fe_total - fe0); end
    n_checks++; if (hash_out !== H_COUNT) begin n_fail++; $display("FAIL good_hash: got %h expected %h", hash_out, H_COUNT); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b expected 0", busy); end
  endtask

  task automatic test_bad_checksum;
    int hv0, fe0;
    hv0 = hv_total; fe0 = fe_total;
    send_frame(H_DEFAULT, 8'hf5);
    n_checks++; if (fe_total - fe0 !== 1) begin n_fail++; $display("FAIL badcks_fe_count: got %0d expected 1", fe_total - fe0); end
    n_checks++; if (hv_total - hv0 !== 0) begin n_fail++; $display("FAIL badcks_hv_count: got %0d expected 0", hv_total - hv0); end
    n_checks++; if (hash_out !== H_COUNT) begin n_fail++; $display("FAIL badcks_hash_kept: got %h expected %h", hash_out, H_COUNT); end
    hv0 = hv_total; fe0 = fe_total;
    send_frame(H_DEFAULT, 8'hf4);
    n_checks++; if (hv_total - hv0 !== 1) begin n_fail++; $display("FAIL goodcks_hv_count: got %0d expected 1", hv_total - hv0); end
    n_checks++; if (fe_total - fe0 !== 0) begin n_fail++; $display("FAIL goodcks_fe_count: got %0d expected 0", fe_total - fe0); end
    n_checks++; if (hash_out !== H_DEFAULT) begin n_fail++; $display("FAIL goodcks_hash: got %h expected %h", hash_out, H_DEFAULT); end
  endtask

  task automatic test_stop_error;
    int hv0, fe0;
    hv0 = hv_total; fe0 = fe_total;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (fe_total - fe0 !== 1) begin n_fail++; $display("FAIL stop_fe_count: got %0d expected 1", fe_total - fe0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b expected 0", busy); end
    n_checks++; if (hv_total - hv0 !== 0) begin n_fail++; $display("FAIL stop_hv_count: got %0d expected 0", hv_total - hv0); end
    // Payload starts with two sync-valued bytes that must be taken as data
    hv0 = hv_total; fe0 = fe_total;
    send_frame(H_SYNCDAT, 8'h0f);
    n_checks++; if (hv_total - hv0 !== 1) begin n_fail++; $display("FAIL after_stop_hv_count: got %0d expected 1", hv_total - hv0); end
    n_checks++; if (fe_total - fe0 !== 0) begin n_fail++; $display("FAIL after_stop_fe_count: got %0d expected 0", fe_total - fe0); end
    n_checks++; if (hash_out !== H_SYNCDAT) begin n_fail++; $display("FAIL after_stop_hash: got %h expected %h", hash_out, H_SYNCDAT); end
  endtask

  task automatic test_timeout;
    int hv0, fe0, cnt, exp_cnt;
    hv0 = hv_total; fe0 = fe_total;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_mid: got %b expected 1", busy); end
    // byte_valid lands 2+HALF+9*CPB cycles after the start bit meets the pin; the error follows TO_CYC later
    exp_cnt = TO_CYC + 3 + HALF - CPB;
    cnt = 0;
    while (frame_err !== 1'b1 && cnt < 25 * CPB) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++; if (cnt !== exp_cnt) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles expected %0d", cnt, exp_cnt); end
    repeat (5 * CPB) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_after: got %b expected 0", busy); end
    n_checks++; if (fe_total - fe0 !== 1) begin n_fail++; $display("FAIL timeout_fe_count: got %0d expected 1", fe_total - fe0); end
    n_checks++; if (hv_total - hv0 !== 0) begin n_fail++; $display("FAIL timeout_hv_count: got %0d expected 0", hv_total - hv0); end
    n_checks++; if (hash_out !== H_SYNCDAT) begin n_fail++; $display("FAIL timeout_hash_kept: got %h expected %h", hash_out, H_SYNCDAT); end
  endtask

  task automatic test_glitch;
    int hv0, fe0;
    hv0 = hv_total; fe0 = fe_total;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (rx_led !== 1'b1) begin n_fail++; $display("FAIL glitch_start_seen: got %b expected 1", rx_led); end
    repeat (3 * CPB) @(negedge clk);
    n_checks++; if (rx_led !== 1'b0) begin n_fail++; $display("FAIL glitch_rx_led: got %b expected 0", rx_led); end
    n_checks++; if (hv_total - hv0 !== 0) begin n_fail++; $display("FAIL glitch_hv_count: got %0d expected 0", hv_total - hv0); end
    n_checks++; if (fe_total - fe0 !== 0) begin n_fail++; $display("FAIL glitch_fe_count: got %0d expected 0", fe_total - fe0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    int hv0;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (hash_out !== H_DEFAULT) begin n_fail++; $display("FAIL midreset_hash: got %h expected %h", hash_out, H_DEFAULT); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (rx_led !== 1'b0) begin n_fail++; $display("FAIL midreset_rx_led: got %b expected 0", rx_led); end
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    hv0 = hv_total;
    send_frame(H_COUNT, 8'h00);
    n_checks++; if (hv_total - hv0 !== 1) begin n_fail++; $display("FAIL postreset_hv_count: got %0d expected 1", hv_total - hv0); end
    n_checks++; if (hash_out !== H_COUNT) begin n_fail++; $display("FAIL postreset_hash: got %h expected %h", hash_out, H_COUNT); end
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    test_good_frame;
    test_bad_checksum;
    test_stop_error;
    test_timeout;
    test_glitch;
    test_reset_mid_frame;
    n_checks++; if (both_total !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_total); end
    n_checks++; if (stray_total !== 0) begin n_fail++; $display("FAIL hash_stability: got %0d stray changes expected 0", stray_total); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
